// File: rtl/calc_array_pipe.sv
// calc_array_pipe: N-lane skewed multiply-add array. A wavefront enters lane 0 and
// reaches lane i i cycles later. Each lane computes sat(sel_a + (sel_x*b >>> FB)) over two stages.
module calc_array_pipe #(
    parameter int N  = 40,
    parameter int BA = 24,
    parameter int BB = 16,
    parameter int FB = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            mode,
    input  logic [N*BA-1:0] a0_bus,
    input  logic [N*BA-1:0] a1_bus,
    input  logic [N*BA-1:0] x0_bus,
    input  logic [N*BA-1:0] x1_bus,
    input  logic [N*BB-1:0] b_bus,
    output logic [N*BA-1:0] out_bus,
    output logic [N-1:0]    out_valid,
    output logic            done,
    output logic [15:0]     wave_cnt
);
    localparam int PW = BA + BB;
    localparam int SW = PW + 1;

    logic [N-1:0] lane_vld_s;
    logic [N-1:0] lane_mode_s;
    logic [15:0]  wave_cnt_r;

    // Clamp a sum to the signed BA range; in range when all bits above the BA sign bit agree.
    function automatic logic [BA-1:0] sat_ba(input logic [SW-1:0] v);
        logic [SW-BA:0] top;
        top = v[SW-1:BA-1];
        if ((&top) || !(|top)) begin
            sat_ba = v[BA-1:0];
        end else if (v[SW-1]) begin
            sat_ba = {1'b1, {(BA-1){1'b0}}};
        end else begin
            sat_ba = {1'b0, {(BA-1){1'b1}}};
        end
    endfunction

    if (N > 1) begin : g_skew
        logic [N-2:0] skew_vld_r;
        logic [N-2:0] skew_mode_r;

        // Skew shift register: mode rides alongside valid so back-to-back wavefronts keep their own mode.
        always_ff @(posedge clk) begin
            if (rst) begin
                skew_vld_r  <= '0;
                skew_mode_r <= '0;
            end else begin
                skew_vld_r[0]  <= in_valid;
                skew_mode_r[0] <= mode;
                for (int k = 1; k < N - 1; k++) begin
                    skew_vld_r[k]  <= skew_vld_r[k-1];
                    skew_mode_r[k] <= skew_mode_r[k-1];
                end
            end
        end

        assign lane_vld_s  = {skew_vld_r, in_valid};
        assign lane_mode_s = {skew_mode_r, mode};
    end else begin : g_noskew
        assign lane_vld_s  = in_valid;
        assign lane_mode_s = mode;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [BA-1:0] a_sel_s;
        logic signed [BA-1:0] x_sel_s;
        logic signed [BB-1:0] b_s;
        logic signed [PW-1:0] x_ext_s;
        logic signed [PW-1:0] b_ext_s;
        logic signed [PW-1:0] prod_sh_s;
        logic        [SW-1:0] sum_s;
        logic                 s1_vld_r;
        logic signed [PW-1:0] s1_prod_r;
        logic signed [BA-1:0] s1_a_r;
        logic                 out_vld_r;
        logic        [BA-1:0] out_r;

        // Operand pair select driven by this lane's skewed mode.
        always_comb begin
            a_sel_s = a0_bus[i*BA +: BA];
            x_sel_s = x0_bus[i*BA +: BA];
            case (lane_mode_s[i])
                1'b0: begin
                    a_sel_s = a0_bus[i*BA +: BA];
                    x_sel_s = x0_bus[i*BA +: BA];
                end
                1'b1: begin
                    a_sel_s = a1_bus[i*BA +: BA];
                    x_sel_s = x1_bus[i*BA +: BA];
                end
                default: begin
                    a_sel_s = '0;
                    x_sel_s = '0;
                end
            endcase
        end

        assign b_s       = b_bus[i*BB +: BB];
        assign x_ext_s   = {{BB{x_sel_s[BA-1]}}, x_sel_s};
        assign b_ext_s   = {{BA{b_s[BB-1]}}, b_s};
        assign prod_sh_s = s1_prod_r >>> FB;
        assign sum_s     = {{(SW-BA){s1_a_r[BA-1]}}, s1_a_r} + {prod_sh_s[PW-1], prod_sh_s};

        // Stage 1: full-width product and selected addend.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_vld_r  <= 1'b0;
                s1_prod_r <= '0;
                s1_a_r    <= '0;
            end else begin
                s1_vld_r <= lane_vld_s[i];
                if (lane_vld_s[i]) begin
                    s1_prod_r <= x_ext_s * b_ext_s;
                    s1_a_r    <= a_sel_s;
                end
            end
        end

        // Stage 2: saturated sum, held until the lane's next valid result.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_vld_r <= 1'b0;
                out_r     <= '0;
            end else begin
                out_vld_r <= s1_vld_r;
                if (s1_vld_r) begin
                    out_r <= sat_ba(sum_s);
                end
            end
        end

        assign out_bus[i*BA +: BA] = out_r;
        assign out_valid[i]        = out_vld_r;
    end

    assign done     = out_valid[N-1];
    assign wave_cnt = wave_cnt_r;

    // Completed-wavefront counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wave_cnt_r <= 16'd0;
        end else if (done) begin
            wave_cnt_r <= wave_cnt_r + 16'd1;
        end else begin
            wave_cnt_r <= wave_cnt_r;
        end
    end
endmodule

// File: tb/tb_calc_array_pipe.sv
// Directed self-checking bench for calc_array_pipe: default 40-lane instance plus a
// scaled 4-lane instance; expected values are hand-computed constants.
module tb_calc_array_pipe;
    localparam int N   = 40;
    localparam int BA  = 24;
    localparam int BB  = 16;
    localparam int SN  = 4;
    localparam int SBA = 12;
    localparam int SBB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, in_valid, mode;
    logic [N*BA-1:0] a0_bus, a1_bus, x0_bus, x1_bus, out_bus;
    logic [N*BB-1:0] b_bus;
    logic [N-1:0]    out_valid;
    logic            done;
    logic [15:0]     wave_cnt;

    logic              s_in_valid, s_mode;
    logic [SN*SBA-1:0] s_a0_bus, s_a1_bus, s_x0_bus, s_x1_bus, s_out_bus;
    logic [SN*SBB-1:0] s_b_bus;
    logic [SN-1:0]     s_out_valid;
    logic              s_done;
    logic [15:0]       s_wave_cnt;

    int check_cnt = 0;
    int fail_cnt  = 0;

    calc_array_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .a0_bus(a0_bus), .a1_bus(a1_bus), .x0_bus(x0_bus), .x1_bus(x1_bus),
        .b_bus(b_bus), .out_bus(out_bus), .out_valid(out_valid),
        .done(done), .wave_cnt(wave_cnt)
    );

    calc_array_pipe #(.N(SN), .BA(SBA), .BB(SBB), .FB(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .mode(s_mode),
        .a0_bus(s_a0_bus), .a1_bus(s_a1_bus), .x0_bus(s_x0_bus), .x1_bus(s_x1_bus),
        .b_bus(s_b_bus), .out_bus(s_out_bus), .out_valid(s_out_valid),
        .done(s_done), .wave_cnt(s_wave_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] onehot(input int k, input int n);
        onehot = 64'd0;
        if (k >= 0 && k < n) onehot[k] = 1'b1;
    endfunction

    task automatic fill(input logic [BA-1:0] a0, input logic [BA-1:0] a1,
                        input logic [BA-1:0] x0, input logic [BA-1:0] x1,
                        input logic [BB-1:0] b);
        for (int i = 0; i < N; i++) begin
            a0_bus[i*BA +: BA] = a0;
            a1_bus[i*BA +: BA] = a1;
            x0_bus[i*BA +: BA] = x0;
            x1_bus[i*BA +: BA] = x1;
            b_bus[i*BB +: BB]  = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        s_in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One wavefront issued now; every lane checked in its result cycle.
    task automatic run_wave(input string tag, input logic md, input logic [BA-1:0] exp);
        in_valid = 1'b1;
        mode = md;
        step();
        in_valid = 1'b0;
        check({tag, "_ov_early"}, 64'(out_valid), 64'd0);
        for (int k = 2; k <= N + 1; k++) begin
            step();
            check({tag, "_ov"}, 64'(out_valid), onehot(k - 2, N));
            check({tag, "_lane"}, 64'(out_bus[(k-2)*BA +: BA]), 64'(exp));
            check({tag, "_done"}, 64'(done), 64'(k == N + 1));
        end
        step();
        check({tag, "_ov_after"}, 64'(out_valid), 64'd0);
        for (int i = 0; i < N; i += 13) begin
            check({tag, "_hold"}, 64'(out_bus[i*BA +: BA]), 64'(exp));
        end
    endtask

    initial begin
        logic [63:0] exp_v;
        int d;
        mode = 1'b0;
        s_mode = 1'b0;
        fill(24'h0, 24'h0, 24'h0, 24'h0, 16'h0);
        s_a0_bus = '0; s_a1_bus = '0; s_x0_bus = '0; s_x1_bus = '0; s_b_bus = '0;
        do_reset();
        check("rst_out_bus", 64'(out_bus == '0), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wave_cnt", 64'(wave_cnt), 64'd0);
        check("rst_small_cnt", 64'(s_wave_cnt), 64'd0);

        // Nominal: 256 + (512*384 >>> 8) = 1024
        fill(24'h000100, 24'h0, 24'h000200, 24'h0, 16'h0180);
        run_wave("nom", 1'b0, 24'h000400);
        check("nom_cnt", 64'(wave_cnt), 64'd1);

        // Mode 1: 16 + (-256*512 >>> 8) = -496
        fill(24'h123456, 24'h000010, 24'h0ABCDE, 24'hFFFF00, 16'h0200);
        run_wave("m1", 1'b1, 24'hFFFE10);
        check("m1_cnt", 64'(wave_cnt), 64'd2);

        fill(24'h7FFFFF, 24'h0, 24'h000100, 24'h0, 16'h0100);
        run_wave("satp", 1'b0, 24'h7FFFFF);
        fill(24'h800000, 24'h0, 24'hFFFF00, 24'h0, 16'h0100);
        run_wave("satn", 1'b0, 24'h800000);
        check("sat_cnt", 64'(wave_cnt), 64'd4);

        // Back-to-back wavefronts, modes 0,1,0,1 -> results 1,2,1,2 per lane
        do_reset();
        fill(24'h000001, 24'h000002, 24'h0, 24'h0, 16'h0123);
        for (int off = 0; off <= N + 6; off++) begin
            in_valid = (off < 4);
            mode = (off % 2 == 1);
            exp_v = 64'd0;
            for (int i = 0; i < N; i++) begin
                d = off - i - 2;
                if (d >= 0 && d <= 3) exp_v[i] = 1'b1;
            end
            check("b2b_ov", 64'(out_valid), exp_v);
            check("b2b_done", 64'(done), 64'(exp_v[N-1]));
            d = off - 2;
            if (d >= 0 && d <= 3)
                check("b2b_lane0", 64'(out_bus[0 +: BA]), (d % 2 == 1) ? 64'd2 : 64'd1);
            d = off - (N - 1) - 2;
            if (d >= 0 && d <= 3)
                check("b2b_laneN", 64'(out_bus[(N-1)*BA +: BA]), (d % 2 == 1) ? 64'd2 : 64'd1);
            step();
        end
        check("b2b_cnt", 64'(wave_cnt), 64'd4);

        // Reset mid-wavefront at offset 10; in_valid during reset must be ignored
        do_reset();
        fill(24'h000100, 24'h0, 24'h000200, 24'h0, 16'h0180);
        for (int off = 0; off <= 53; off++) begin
            in_valid = (off == 0 || off == 10 || off == 11);
            mode = 1'b0;
            rst = (off == 10);
            exp_v = (off <= 10) ? onehot(off - 2, N) : onehot(off - 13, N);
            check("rmid_ov", 64'(out_valid), exp_v);
            check("rmid_done", 64'(done), 64'(exp_v[N-1]));
            if (off == 11) begin
                check("rmid_bus_clr", 64'(out_bus == '0), 64'd1);
                check("rmid_cnt_clr", 64'(wave_cnt), 64'd0);
            end
            if (off >= 13 && off - 13 < N)
                check("rmid_lane", 64'(out_bus[(off-13)*BA +: BA]), 64'h400);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        check("rmid_cnt", 64'(wave_cnt), 64'd1);

        // Scaled instance: 16 + (32*24 >>> 4) = 64
        for (int i = 0; i < SN; i++) begin
            s_a0_bus[i*SBA +: SBA] = 12'h010;
            s_x0_bus[i*SBA +: SBA] = 12'h020;
            s_b_bus[i*SBB +: SBB]  = 8'h18;
        end
        for (int off = 0; off <= 7; off++) begin
            s_in_valid = (off == 0);
            check("sm_ov", 64'(s_out_valid), onehot(off - 2, SN));
            check("sm_done", 64'(s_done), 64'(off == 5));
            if (off >= 2 && off - 2 < SN)
                check("sm_lane", 64'(s_out_bus[(off-2)*SBA +: SBA]), 64'h040);
            if (off == 6) check("sm_cnt1", 64'(s_wave_cnt), 64'd1);
            step();
        end
        s_in_valid = 1'b1;
        for (int k = 0; k < 65535; k++) step();
        s_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check("sm_wrap", 64'(s_wave_cnt), 64'd0);
        check("sm_hold", 64'(s_out_bus[(SN-1)*SBA +: SBA]), 64'h040);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end
endmodule
